// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with a byte FIFO.
//
// Register window (two words at BASE_ADDR; dmem_addr[1:0] ignored):
//   +0x0 DATA   W: push dmem_in[7:0] into the TX FIFO (dropped and ovf set if full)
//               R: reads as zero
//   +0x4 STATUS R: {16'b0, count[7:0], 4'b0, ovf, busy, full, empty}
//               W: any write clears ovf
//
// Ports:
//   clk_in     single rising-edge clock
//   reset      synchronous, active-low reset
//   dmem_ena   CPU data-port access strobe
//   dmem_wena  CPU write enable (qualified by dmem_ena)
//   dmem_addr  CPU byte address
//   dmem_in    CPU store data (bits [7:0] used)
//   sel        combinational window hit, used by the top level to steer read data
//   rdata      combinational register read data (zero when sel is low)
//   txd        serial output, idles high; frame = start, 8 data LSB first, stop
//
// Optional build macro UART_PARITY_EN adds an even-parity bit after the data
// bits (11-bit frame). Without it the frame is 10 bits.

module mmio_uart_tx #(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        dmem_ena,
    input  logic        dmem_wena,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_in,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [15:0] TMR_RELOAD = 16'(CLK_DIV - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      shifter;
    logic [2:0]      bit_idx;
    logic [15:0]     bit_tmr;
    logic            ovf;
    logic            par_bit;
    logic            empty, full, busy;
    logic            wr_data, wr_status, push, pop, shift_en, tmr_done;
    logic            unused_bits;

    // Upper store-data bits and the byte offset within a word carry no meaning here.
    assign unused_bits = ^{dmem_in[31:8], dmem_addr[1:0]};

    assign sel       = (dmem_addr[31:3] == BASE_ADDR[31:3]);
    assign wr_data   = dmem_ena & dmem_wena & sel & ~dmem_addr[2];
    assign wr_status = dmem_ena & dmem_wena & sel &  dmem_addr[2];
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = wr_data & ~full;
    assign busy      = (state != IDLE);
    assign tmr_done  = (bit_tmr == '0);

    always_comb begin
        rdata = '0;
        if (sel && dmem_addr[2])
            rdata = {16'b0, 8'(count), 4'b0, ovf, busy, full, empty};
    end

    // Next-state and line output
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shift_en  = 1'b0;
        txd       = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (tmr_done) state_nxt = DATA;
            end
            DATA: begin
                txd = shifter[0];
                if (tmr_done) begin
                    if (bit_idx == 3'd7)
`ifdef UART_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    else
                        shift_en = 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                txd = par_bit;
                if (tmr_done) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (tmr_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FIFO storage needs no reset; a reset edge must not write into it.
    always_ff @(posedge clk_in) begin
        if (reset && push) mem[wr_ptr] <= dmem_in[7:0];
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            bit_tmr <= '0;
            bit_idx <= '0;
            shifter <= '0;
            par_bit <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (wr_status)          ovf <= 1'b0;
            else if (wr_data && full) ovf <= 1'b1;

            // Timer reloads on every state or bit change; parked at zero in IDLE.
            if (state_nxt == IDLE)                     bit_tmr <= '0;
            else if (state_nxt != state || shift_en)   bit_tmr <= TMR_RELOAD;
            else                                       bit_tmr <= bit_tmr - 16'd1;

            if (pop) begin
                shifter <= mem[rd_ptr];
                par_bit <= ^mem[rd_ptr];
            end else if (shift_en) begin
                shifter <= {1'b0, shifter[7:1]};
            end

            if (state != DATA)  bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
- REQ-001 SHALL have parameter CLK_DIV, default 868: clk_in cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..64.
- REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_4000: word-aligned base of the 2-word register window.
- REQ-004 SHALL have port clk_in, input, 1: the single clock; all logic is rising-edge.
- REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-low.
- REQ-006 SHALL have port dmem_ena, input, 1: CPU data-port access strobe.
- REQ-007 SHALL have port dmem_wena, input, 1: CPU write enable; valid only with dmem_ena.
- REQ-008 SHALL have port dmem_addr, input, 32: CPU byte address.
- REQ-009 SHALL have port dmem_in, input, 32: CPU store data; only bits [7:0] are used.
- REQ-010 SHALL have port sel, output, 1: combinational high when dmem_addr[31:3] == BASE_ADDR[31:3]; the top level steers dmem_out from this block instead of RAM.
- REQ-011 SHALL have port rdata, output, 32: combinational register read data.
- REQ-012 SHALL have port txd, output, 1: serial line; idles high.

Function
- REQ-013 SHALL decode DATA at offset 0x0 and STATUS at offset 0x4; dmem_addr[1:0] are ignored.
- REQ-014 SHALL push dmem_in[7:0] into the FIFO on a clock edge where dmem_ena & dmem_wena & sel & offset 0x0.
- REQ-015 SHALL NOT push when the FIFO is full; the byte is dropped and sticky flag ovf is set.
- REQ-016 SHALL clear ovf on any write to STATUS.
- REQ-017 SHALL drive rdata for a STATUS read as {16'b0, count[7:0], 4'b0, ovf, busy, full, empty}, where count is the FIFO occupancy.
- REQ-018 SHALL drive rdata = 32'b0 for a DATA read and whenever sel is low.
- REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
- REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head into the shift register and enter START on the same edge.
- REQ-021 SHALL hold each state for exactly CLK_DIV cycles, using a bit timer that reloads on every state or bit change.
- REQ-022 SHALL drive txd as follows: START = 0; DATA = 8 bits, LSB first; STOP = 1; IDLE = 1.
- REQ-023 SHALL make transitions DATA->STOP (or DATA->PARITY), PARITY->STOP and STOP->IDLE; STOP followed by a non-empty FIFO passes through IDLE for exactly 1 cycle before the next START.
- REQ-024 SHALL give a latency of one edge from write to start bit: a write at edge N into an empty FIFO in IDLE yields txd = 0 from edge N+1.
- REQ-025 SHALL handle a simultaneous push and pop as count unchanged, with both operations taking effect.
- REQ-026 SHALL assert busy whenever the state is not IDLE.
- REQ-027 SHALL let FIFO pointers wrap modulo FIFO_DEPTH; full is count == FIFO_DEPTH and empty is count == 0.

Reset
- REQ-028 SHALL, on an edge with reset == 0, set state = IDLE, txd = 1, FIFO empty (pointers and count 0), ovf = 0 and bit timer 0.
- REQ-029 SHALL abort a frame in progress on reset mid-frame: txd goes high on the reset edge and no partial remainder is sent.
- REQ-030 SHALL ignore pushes on reset edges.

Configuration
- REQ-031 SHALL, with macro UART_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) after DATA for CLK_DIV cycles; the frame is 11 bits.
- REQ-032 SHALL, without UART_PARITY_EN, omit the PARITY state entirely; the frame is 10 bits and the STATUS layout is unchanged.

Verification (CLK_DIV=4, FIFO_DEPTH=8)
- REQ-033 SHALL cover: write 0x55 to DATA -> txd from the next edge = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high for 40 cycles, then txd = 1.
- REQ-034 SHALL cover: 10 back-to-back DATA writes while idle -> 1 in shifter, 8 in FIFO, 10th dropped; STATUS reads 0x0000_080E (count 8, ovf, busy, full); a STATUS write then clears ovf.
- REQ-035 SHALL cover: write 0xA1, 0xB2 -> two frames separated by exactly 1 idle-high cycle; STATUS reads 0x0000_0001 afterwards.
- REQ-036 SHALL cover: assert reset low during DATA bit 3 -> txd = 1, STATUS = 0x0000_0001 next cycle; no further start bit appears.
- REQ-037 SHALL cover, with UART_PARITY_EN: write 0x07 -> parity bit 1; frame length 44 cycles.
- REQ-038 SHALL cover: read dmem_addr = BASE_ADDR + 8 -> sel = 0, rdata = 0, FIFO unaffected.
